// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multi-cycle issue controller feeding a 4-bit-op combinational ALU
// Optional debug read port and state visibility: define ALU_ISSUE_DBG_EN
module alu_issue_ctrl #(
   parameter int NREGS = 32,
   parameter int RAW   = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [31:0]      instr,
   output logic [31:0]      alu_data1,
   output logic [31:0]      alu_data2,
   output logic [3:0]       alu_op,
   input  logic [31:0]      alu_result,
   output logic             mem_wr_valid,
   input  logic             mem_wr_ready,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
`ifdef ALU_ISSUE_DBG_EN
   ,
   input  logic [RAW-1:0]   dbg_raddr,
   output logic [31:0]      dbg_rdata,
   output logic [2:0]       dbg_state
`endif
);

   localparam logic [5:0] OPC_ARITH = 6'b000000;
   localparam logic [5:0] OPC_SW    = 6'b101011;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_STORE  = 3'd4
   } state_t;

   state_t      r_state;
   logic [31:0] r_ir;
   logic [31:0] r_result;
   logic [31:0] r_regs [NREGS];

   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;
   logic [4:0]  w_fld_a;
   logic [4:0]  w_fld_b;
   logic [4:0]  w_fld_c;
   logic [31:0] w_val_a;
   logic [31:0] w_val_b;
   logic [31:0] w_val_c;
   logic [31:0] w_imm_sx;
   logic [3:0]  w_op;
   logic        w_funct_ok;
   logic        w_is_arith;
   logic        w_is_sw;

   // Field a is rd (ARITH) or base (SW); b is rs1 or src; c is rs2.
   assign w_opcode = r_ir[31:26];
   assign w_funct  = r_ir[5:0];
   assign w_fld_a  = r_ir[25:21];
   assign w_fld_b  = r_ir[20:16];
   assign w_fld_c  = r_ir[15:11];
   assign w_imm_sx = {{16{r_ir[15]}}, r_ir[15:0]};

   // r0 is never written, but the guard keeps its read value tied to zero regardless.
   assign w_val_a = (w_fld_a == 5'd0) ? 32'd0 : r_regs[w_fld_a];
   assign w_val_b = (w_fld_b == 5'd0) ? 32'd0 : r_regs[w_fld_b];
   assign w_val_c = (w_fld_c == 5'd0) ? 32'd0 : r_regs[w_fld_c];

   // Translate the ARITH funct field into the ALU operation code.
   always_comb begin
      w_op       = 4'b0000;
      w_funct_ok = 1'b1;
      case (w_funct)
         6'h24:   w_op = 4'b0000;
         6'h25:   w_op = 4'b0001;
         6'h20:   w_op = 4'b0010;
         6'h22:   w_op = 4'b0110;
         6'h2A:   w_op = 4'b0111;
         6'h27:   w_op = 4'b1100;
         default: w_funct_ok = 1'b0;
      endcase
   end

   assign w_is_arith = (w_opcode == OPC_ARITH) && w_funct_ok;
   assign w_is_sw    = (w_opcode == OPC_SW);

   // Issue FSM with register file, ALU operand registers and store port, all registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         instr_ready  <= 1'b1;
         r_ir         <= 32'd0;
         r_result     <= 32'd0;
         alu_data1    <= 32'd0;
         alu_data2    <= 32'd0;
         alu_op       <= 4'b0000;
         mem_wr_valid <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         illegal      <= 1'b0;
         retired      <= '0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= 32'd0;
      end else begin
         illegal <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (instr_valid && instr_ready) begin
                  r_ir        <= instr;
                  instr_ready <= 1'b0;
                  r_state     <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_is_arith) begin
                  alu_data1 <= w_val_b;
                  alu_data2 <= w_val_c;
                  alu_op    <= w_op;
                  r_state   <= S_EXEC;
               end else if (w_is_sw) begin
                  alu_data1 <= w_val_a;
                  alu_data2 <= w_imm_sx;
                  alu_op    <= 4'b0010;
                  mem_wdata <= w_val_b;
                  r_state   <= S_EXEC;
               end else begin
                  // Operand registers keep their previous values on a rejected instruction.
                  illegal     <= 1'b1;
                  instr_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            S_EXEC: begin
               if (w_opcode == OPC_SW) begin
                  mem_addr     <= alu_result;
                  mem_wr_valid <= 1'b1;
                  r_state      <= S_STORE;
               end else begin
                  r_result <= alu_result;
                  r_state  <= S_WB;
               end
            end
            S_WB: begin
               if (w_fld_a != 5'd0) r_regs[w_fld_a] <= r_result;
               retired     <= retired + CNT_W'(1);
               instr_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            S_STORE: begin
               if (mem_wr_ready) begin
                  mem_wr_valid <= 1'b0;
                  retired      <= retired + CNT_W'(1);
                  instr_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               instr_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_ISSUE_DBG_EN
   assign dbg_rdata = (dbg_raddr == '0) ? 32'd0 : r_regs[dbg_raddr];
   assign dbg_state = r_state;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] alu_data1;
   logic [31:0] alu_data2;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        mem_wr_valid;
   logic        mem_wr_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        illegal;
   logic [15:0] retired;

   logic        force_en;
   logic [31:0] force_val;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .alu_data1    (alu_data1),
      .alu_data2    (alu_data2),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_ready (mem_wr_ready),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .illegal      (illegal),
      .retired      (retired)
   );

   // Stand-in for the external combinational ALU; force_en lets the bench inject arbitrary results.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return (a < b) ? 32'd1 : 32'd0;
         4'b1100: return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   assign alu_result = force_en ? force_val : alu_fn(alu_op, alu_data1, alu_data2);

   // Reference model state: architectural registers, retired count, last issued ALU inputs.
   logic [31:0] ref_regs [32];
   logic [15:0] ref_ret;
   logic [3:0]  m_op;
   logic [31:0] m_d1, m_d2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] obs_d1, obs_d2, obs_addr, obs_wdata;
   logic [3:0]  obs_op;
   logic        obs_ill;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ar(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [5:0] fn);
      return {6'b000000, rd, rs1, rs2, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] sw(input logic [4:0] base, input logic [4:0] src, input logic [15:0] imm);
      return {6'b101011, base, src, imm};
   endfunction

   function automatic logic [3:0] op_of(input logic [5:0] fn);
      case (fn)
         6'h24:   return 4'b0000;
         6'h25:   return 4'b0001;
         6'h20:   return 4'b0010;
         6'h22:   return 4'b0110;
         6'h2A:   return 4'b0111;
         default: return 4'b1100;
      endcase
   endfunction

   function automatic logic [31:0] ref_exec(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      case (fn)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h27:   return ~(a | b);
         default: return (a < b) ? 32'd1 : 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
      ref_ret = 16'd0;
      m_op    = 4'b0000;
      m_d1    = 32'd0;
      m_d2    = 32'd0;
   endtask

   // Issue one instruction from an idle negedge and follow it to completion with fixed cycle counts.
   task automatic run_instr(input logic [31:0] ins, input logic fen, input logic [31:0] fval, input int stall);
      logic [5:0]  opc, fn;
      logic [4:0]  fa, fb, fc;
      logic        is_ar, is_sw;
      logic [31:0] a, b, res, wd;
      logic [3:0]  eop;
      opc   = ins[31:26];
      fn    = ins[5:0];
      fa    = ins[25:21];
      fb    = ins[20:16];
      fc    = ins[15:11];
      is_sw = (opc == 6'b101011);
      is_ar = (opc == 6'b000000) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
      chk("ready_idle", 32'(instr_ready), 32'd1);
      force_en     = fen;
      force_val    = fval;
      mem_wr_ready = is_sw ? 1'b0 : 1'($urandom_range(0, 1));
      instr        = ins;
      instr_valid  = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = $urandom;
      chk("ready_decode", 32'(instr_ready), 32'd0);
      @(negedge clk);
      obs_op  = alu_op;
      obs_d1  = alu_data1;
      obs_d2  = alu_data2;
      obs_ill = illegal;
      if (!is_ar && !is_sw) begin
         chk("ill_pulse", 32'(illegal), 32'd1);
         chk("ill_ready", 32'(instr_ready), 32'd1);
         chk("ill_op_hold", 32'(alu_op), 32'(m_op));
         chk("ill_d1_hold", alu_data1, m_d1);
         chk("ill_d2_hold", alu_data2, m_d2);
         chk("ill_retired", 32'(retired), 32'(ref_ret));
         @(negedge clk);
         chk("ill_drop", 32'(illegal), 32'd0);
         chk("ill_retired2", 32'(retired), 32'(ref_ret));
      end else begin
         chk("exec_ill", 32'(illegal), 32'd0);
         if (is_ar) begin
            a   = ref_regs[fb];
            b   = ref_regs[fc];
            eop = op_of(fn);
            res = fen ? fval : ref_exec(fn, a, b);
         end else begin
            a   = ref_regs[fa];
            b   = 32'($signed(ins[15:0]));
            eop = 4'b0010;
            res = fen ? fval : a + b;
         end
         chk("exec_op", 32'(alu_op), 32'(eop));
         chk("exec_d1", alu_data1, a);
         chk("exec_d2", alu_data2, b);
         m_op = eop;
         m_d1 = a;
         m_d2 = b;
         @(negedge clk);
         if (is_ar) begin
            chk("wb_ready", 32'(instr_ready), 32'd0);
            chk("wb_novalid", 32'(mem_wr_valid), 32'd0);
            @(negedge clk);
            if (fa != 5'd0) ref_regs[fa] = res;
            ref_ret++;
            chk("ar_ready_back", 32'(instr_ready), 32'd1);
            chk("ar_retired", 32'(retired), 32'(ref_ret));
         end else begin
            wd = ref_regs[fb];
            for (int i = 0; i <= stall; i++) begin
               if (i > 0) @(negedge clk);
               chk("st_valid", 32'(mem_wr_valid), 32'd1);
               chk("st_addr", mem_addr, res);
               chk("st_wdata", mem_wdata, wd);
               chk("st_retired", 32'(retired), 32'(ref_ret));
               chk("st_ready", 32'(instr_ready), 32'd0);
               if (i == stall) mem_wr_ready = 1'b1;
            end
            obs_addr  = mem_addr;
            obs_wdata = mem_wdata;
            @(negedge clk);
            mem_wr_ready = 1'b0;
            ref_ret++;
            chk("st_done_valid", 32'(mem_wr_valid), 32'd0);
            chk("st_done_ready", 32'(instr_ready), 32'd1);
            chk("st_done_retired", 32'(retired), 32'(ref_ret));
         end
      end
      force_en = 1'b0;
   endtask

   typedef struct {
      logic [31:0] ins;
      logic        fen;
      logic [31:0] fval;
      int          stall;
      logic        ill;
      logic [3:0]  op;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] addr;
      logic [31:0] wdata;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rins;
      logic [5:0]  functs [6];
      int          sel;
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

      tbl.push_back('{ar(5'd1, 5'd0, 5'd0, 6'h20), 1'b1, 32'd5,          0, 1'b0, 4'b0010, 32'd0,          32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd2, 5'd0, 5'd0, 6'h20), 1'b1, 32'd7,          0, 1'b0, 4'b0010, 32'd0,          32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd3, 5'd1, 5'd2, 6'h20), 1'b0, 32'd0,          0, 1'b0, 4'b0010, 32'd5,          32'd7,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd0, 5'd3, 5'd0, 6'h25), 1'b0, 32'd0,          0, 1'b0, 4'b0001, 32'd12,         32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd1, 5'd0, 5'd0, 6'h20), 1'b1, 32'h0000000F,   0, 1'b0, 4'b0010, 32'd0,          32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd2, 5'd0, 5'd0, 6'h20), 1'b1, 32'h000000F0,   0, 1'b0, 4'b0010, 32'd0,          32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd4, 5'd1, 5'd2, 6'h22), 1'b0, 32'd0,          0, 1'b0, 4'b0110, 32'h0000000F,   32'h000000F0,   32'd0,     32'd0});
      tbl.push_back('{ar(5'd5, 5'd1, 5'd2, 6'h2A), 1'b0, 32'd0,          0, 1'b0, 4'b0111, 32'h0000000F,   32'h000000F0,   32'd0,     32'd0});
      tbl.push_back('{ar(5'd6, 5'd1, 5'd2, 6'h27), 1'b0, 32'd0,          0, 1'b0, 4'b1100, 32'h0000000F,   32'h000000F0,   32'd0,     32'd0});
      tbl.push_back('{ar(5'd7, 5'd1, 5'd2, 6'h24), 1'b0, 32'd0,          0, 1'b0, 4'b0000, 32'h0000000F,   32'h000000F0,   32'd0,     32'd0});
      tbl.push_back('{ar(5'd8, 5'd1, 5'd2, 6'h25), 1'b0, 32'd0,          0, 1'b0, 4'b0001, 32'h0000000F,   32'h000000F0,   32'd0,     32'd0});
      tbl.push_back('{ar(5'd0, 5'd4, 5'd5, 6'h25), 1'b0, 32'd0,          0, 1'b0, 4'b0001, 32'hFFFFFF1F,   32'd1,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd0, 5'd6, 5'd7, 6'h25), 1'b0, 32'd0,          0, 1'b0, 4'b0001, 32'hFFFFFF00,   32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd0, 5'd8, 5'd0, 6'h25), 1'b0, 32'd0,          0, 1'b0, 4'b0001, 32'h000000FF,   32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd1, 5'd0, 5'd0, 6'h20), 1'b1, 32'h00000100,   0, 1'b0, 4'b0010, 32'd0,          32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd2, 5'd0, 5'd0, 6'h20), 1'b1, 32'hCAFEF00D,   0, 1'b0, 4'b0010, 32'd0,          32'd0,          32'd0,     32'd0});
      tbl.push_back('{sw(5'd1, 5'd2, 16'hFFFC),    1'b0, 32'd0,          3, 1'b0, 4'b0010, 32'h00000100,   32'hFFFFFFFC,   32'h000000FC, 32'hCAFEF00D});
      tbl.push_back('{ar(5'd0, 5'd1, 5'd2, 6'h20), 1'b0, 32'd0,          0, 1'b0, 4'b0010, 32'h00000100,   32'hCAFEF00D,   32'd0,     32'd0});
      tbl.push_back('{ar(5'd0, 5'd0, 5'd0, 6'h25), 1'b0, 32'd0,          0, 1'b0, 4'b0001, 32'd0,          32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd3, 5'd1, 5'd2, 6'h3F), 1'b0, 32'd0,          0, 1'b1, 4'b0001, 32'd0,          32'd0,          32'd0,     32'd0});
      tbl.push_back('{32'hFC221800,                1'b0, 32'd0,          0, 1'b1, 4'b0001, 32'd0,          32'd0,          32'd0,     32'd0});
      tbl.push_back('{ar(5'd0, 5'd3, 5'd1, 6'h25), 1'b0, 32'd0,          0, 1'b0, 4'b0001, 32'd12,         32'h00000100,   32'd0,     32'd0});

      rst          = 1'b1;
      instr_valid  = 1'b0;
      instr        = 32'd0;
      mem_wr_ready = 1'b0;
      force_en     = 1'b0;
      force_val    = 32'd0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_valid", 32'(mem_wr_valid), 32'd0);
      chk("rst_op", 32'(alu_op), 32'd0);
      chk("rst_d1", alu_data1, 32'd0);
      chk("rst_d2", alu_data2, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);

      // Directed vectors
      foreach (tbl[k]) begin
         run_instr(tbl[k].ins, tbl[k].fen, tbl[k].fval, tbl[k].stall);
         chk($sformatf("vec%0d_ill", k), 32'(obs_ill), 32'(tbl[k].ill));
         chk($sformatf("vec%0d_op", k), 32'(obs_op), 32'(tbl[k].op));
         chk($sformatf("vec%0d_d1", k), obs_d1, tbl[k].d1);
         chk($sformatf("vec%0d_d2", k), obs_d2, tbl[k].d2);
         if (tbl[k].ins[31:26] == 6'b101011) begin
            chk($sformatf("vec%0d_addr", k), obs_addr, tbl[k].addr);
            chk($sformatf("vec%0d_wdata", k), obs_wdata, tbl[k].wdata);
         end
      end
      chk("vec_retired_total", 32'(retired), 32'd20);

      // Randomized instruction stream against the reference model
      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6) begin
            rins = ar(5'($urandom), 5'($urandom), 5'($urandom), functs[$urandom_range(0, 5)]);
         end else if (sel < 8) begin
            rins = sw(5'($urandom), 5'($urandom), 16'($urandom));
         end else if (sel == 8) begin
            rins = ar(5'($urandom), 5'($urandom), 5'($urandom), 6'h01);
         end else begin
            rins = {6'b111111, 26'($urandom)};
         end
         run_instr(rins, ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
      end

      // Reset while a store is waiting for the memory
      instr        = sw(5'd1, 5'd2, 16'h0010);
      instr_valid  = 1'b1;
      mem_wr_ready = 1'b0;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_store_valid", 32'(mem_wr_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("rst2_valid", 32'(mem_wr_valid), 32'd0);
      chk("rst2_ready", 32'(instr_ready), 32'd1);
      chk("rst2_retired", 32'(retired), 32'd0);
      chk("rst2_op", 32'(alu_op), 32'd0);
      chk("rst2_d1", alu_data1, 32'd0);
      chk("rst2_addr", mem_addr, 32'd0);
      chk("rst2_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      chk("rst2_valid_stays", 32'(mem_wr_valid), 32'd0);
      chk("rst2_retired_stays", 32'(retired), 32'd0);
      for (int r = 0; r < 32; r += 2) begin
         run_instr(ar(5'd0, 5'(r), 5'(r + 1), 6'h25), 1'b0, 32'd0, 0);
         chk("rst2_reg_even", obs_d1, 32'd0);
         chk("rst2_reg_odd", obs_d2, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator-side companion to the 4-bit-op combinational ALU: accepts instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal register file, drives the ALU's data1/data2/op inputs, samples its result, and either writes back to a register or issues a store request.
- Sits between instruction fetch and the ALU/data-memory write port; one instruction in flight at a time (multi-cycle, no pipelining).

Parameters:
- NREGS, 32, number of architectural registers; r0 reads 0 and ignores writes.
- RAW, 5, register index width; log2(NREGS).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- instr_valid  in  1  instruction word offered.
- instr_ready  out  1  controller can accept; high only in IDLE.
- instr  in  32  instruction word.
- alu_data1  out  32  ALU operand 1, driven from a register.
- alu_data2  out  32  ALU operand 2, driven from a register.
- alu_op  out  4  ALU operation, driven from a register.
- alu_result  in  32  combinational ALU output.
- mem_wr_valid  out  1  store request pending.
- mem_wr_ready  in  1  memory accepts store.
- mem_addr  out  32  store address.
- mem_wdata  out  32  store data.
- illegal  out  1  one-cycle pulse when an undecodable instruction is accepted.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - FSM=IDLE; all registers r0..rN-1=0.
  - alu_data1=0, alu_data2=0, alu_op=4'b0000.
  - mem_wr_valid=0, mem_addr=0, mem_wdata=0, illegal=0, retired=0.
  - Reset mid-operation abandons the instruction: no writeback, and any pending store is dropped the cycle after rst.
- Instruction formats:
  - ARITH: [31:26]=6'b000000, [25:21]=rd, [20:16]=rs1, [15:11]=rs2, [5:0]=funct.
  - SW: [31:26]=6'b101011, [25:21]=base, [20:16]=src, [15:0]=imm.
- funct to alu_op mapping:
  - 0x24 AND -> 0000
  - 0x25 OR -> 0001
  - 0x20 ADD -> 0010
  - 0x22 SUB -> 0110
  - 0x2A SLT -> 0111
  - 0x27 NOR -> 1100
  - Any other funct, or any other opcode, is illegal.
- FSM states: IDLE, DECODE, EXEC, WB, STORE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, capture instr into IR and go to DECODE.
- DECODE:
  - Legal ARITH: alu_data1<=R[rs1], alu_data2<=R[rs2], alu_op<=mapped op.
  - SW: alu_data1<=R[base], alu_data2<=sign-extended imm, alu_op<=0010, mem_wdata<=R[src].
  - Legal instruction -> EXEC.
  - Illegal: illegal=1 for exactly the next cycle, operand/op registers unchanged, retired unchanged -> IDLE.
- EXEC: alu_result is sampled at the end of the cycle.
  - ARITH -> WB, holding the sampled result.
  - SW -> mem_addr<=alu_result, mem_wr_valid<=1, go to STORE.
- WB: R[rd]<=result unless rd=0; retired++; -> IDLE.
- STORE:
  - mem_wr_valid, mem_addr and mem_wdata are held stable until mem_wr_ready.
  - On the cycle with mem_wr_ready=1: mem_wr_valid<=0, retired++, -> IDLE.
  - mem_wr_ready while not in STORE is ignored.
- Latency:
  - ARITH accepted in cycle N: register updated at end of N+3; instr_ready high again in N+4.
  - SW accepted in cycle N: mem_wr_valid first high in N+3.
- Hazards: none possible (single issue). An instruction reading a register written by the previous one sees the new value.
- retired wraps modulo 2^CNT_W.
- Arithmetic:
  - All 32-bit, no overflow flag.
  - SLT semantics are the ALU's (unsigned compare); the controller does not reinterpret them.
- alu_op/alu_data hold their last values outside EXEC; the ALU output is ignored there.

Optional Feature:
- Macro: ALU_ISSUE_DBG_EN.
- When defined:
  - Adds input dbg_raddr[RAW] and output dbg_rdata[32]: a combinational read of R[dbg_raddr] (0 for r0).
  - Adds output dbg_state[3], the current FSM encoding: IDLE=0, DECODE=1, EXEC=2, WB=3, STORE=4.
- When undefined: these ports do not exist; functional behaviour is otherwise identical.

Test Plan:
- Reset then ADD r3,r1,r2 with R1=5, R2=7 (preloaded via ADDs from r0 path, e.g. OR r1,r0,r0 yields 0) -> alu_op=0010 in EXEC, R3=12, retired increments by 1, instr_ready returns 4 cycles after acceptance.
- SUB/SLT/NOR/AND/OR sequence with R1=0x0000000F, R2=0x000000F0 -> R results 0xFFFFFF1F (SUB), 1 (SLT), 0xFFFFFF00 (NOR), 0x00000000 (AND), 0x000000FF (OR).
- SW base=r1 (0x100), src=r2, imm=0xFFFC with mem_wr_ready low for 3 cycles -> mem_addr=0x000000FC and mem_wdata=R2, both held stable with mem_wr_valid=1 for 4 cycles; retired increments only on the handshake cycle.
- Write to r0 (ADD r0,r1,r2) -> r0 still reads 0; retired increments.
- Illegal funct 0x3F, then opcode 6'b111111 -> illegal pulses 1 cycle each, no register change, retired unchanged, next instruction accepted normally.
- Assert rst during STORE with mem_wr_ready=0 -> mem_wr_valid=0 and FSM=IDLE the cycle after, all registers 0, retired=0.
